mr_control_unit: RTL and testbench

Control unit of the Máquina Rudimentaria CPU: a synchronous fetch/decode/execute state machine that decodes the 16-bit instruction held in the datapath instruction register and drives every datapath load/select strobe. It is the stage directly upstream of the register bank, generating its `ld`, `addr_R` and `addr_W` inputs, and it also controls the PC, IR, operand register, ALU, flags and data memory. Instructions complete in 2 cycles (branches) or 3 cycles (LOAD, STORE, ALU).

---
 rtl/mr_control_unit.sv | 132 +++++++++++++
 tb/tb_mr_control_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mr_control_unit.sv
// Máquina Rudimentaria control unit: fetch/decode/execute FSM that decodes the
// instruction register and drives all datapath strobes combinationally from state.
module mr_control_unit #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] ir,
    input  logic          z,
    input  logic          n,
    output logic          ld_ir,
    output logic          ld_pc,
    output logic          sel_pc,
    output logic          sel_addr,
    output logic          mem_we,
    output logic          ld_ra,
    output logic          regb_ld,
    output logic [AW-1:0] regb_addr_R,
    output logic [AW-1:0] regb_addr_W,
    output logic          sel_regb_in,
    output logic          sel_b,
    output logic [2:0]    alu_op,
    output logic          ld_flags,
    output logic          done
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_LOAD   = 3'd2,
        S_STORE  = 3'd3,
        S_ALU    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_taken;
    logic   w_rsv_op;
    logic   w_rd_nz;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    // Condition codes 100 is reserved and never taken.
    always_comb begin
        w_taken = 1'b0;
        case (ir[13:11])
            3'b000:  w_taken = 1'b1;
            3'b001:  w_taken = z;
            3'b010:  w_taken = n;
            3'b011:  w_taken = n | z;
            3'b101:  w_taken = ~z;
            3'b110:  w_taken = ~n;
            3'b111:  w_taken = ~(n | z);
            default: w_taken = 1'b0;
        endcase
    end

    assign w_rsv_op = (ir[2:1] == 2'b01);
    assign w_rd_nz  = (ir[13:11] != 3'b000);

    always_comb begin
        w_next      = S_FETCH;
        ld_ir       = 1'b0;
        ld_pc       = 1'b0;
        sel_pc      = 1'b0;
        sel_addr    = 1'b0;
        mem_we      = 1'b0;
        ld_ra       = 1'b0;
        regb_ld     = 1'b0;
        regb_addr_R = '0;
        regb_addr_W = '0;
        sel_regb_in = 1'b0;
        sel_b       = 1'b0;
        alu_op      = 3'b000;
        ld_flags    = 1'b0;
        done        = 1'b0;
        // Reset blanks every strobe so an aborted instruction cannot write state.
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    ld_ir  = 1'b1;
                    ld_pc  = 1'b1;
                    w_next = S_DECODE;
                end
                S_DECODE: begin
                    regb_addr_R = ir[10:8];
                    ld_ra       = 1'b1;
                    case (ir[15:14])
                        2'b00:   w_next = S_LOAD;
                        2'b01:   w_next = S_STORE;
                        2'b11:   w_next = S_ALU;
                        default: begin
                            ld_pc  = w_taken;
                            sel_pc = w_taken;
                            done   = 1'b1;
                            w_next = S_FETCH;
                        end
                    endcase
                end
                S_LOAD: begin
                    sel_addr    = 1'b1;
                    regb_addr_W = ir[13:11];
                    regb_ld     = w_rd_nz;
                    ld_flags    = 1'b1;
                    done        = 1'b1;
                end
                S_STORE: begin
                    sel_addr    = 1'b1;
                    regb_addr_R = ir[13:11];
                    mem_we      = 1'b1;
                    done        = 1'b1;
                end
                S_ALU: begin
                    regb_addr_R = ir[7:5];
                    sel_b       = ~ir[2];
                    alu_op      = ir[2:0];
                    sel_regb_in = 1'b1;
                    regb_addr_W = ir[13:11];
                    regb_ld     = w_rd_nz & ~w_rsv_op;
                    ld_flags    = ~w_rsv_op;
                    done        = 1'b1;
                end
                default: w_next = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mr_control_unit.sv
// Cycle-by-cycle trace of mr_control_unit against hand-computed strobe vectors.
module tb_mr_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ir = '0;
    logic        z = 1'b0;
    logic        n = 1'b0;
    logic        ld_ir, ld_pc, sel_pc, sel_addr, mem_we, ld_ra, regb_ld;
    logic [2:0]  regb_addr_R, regb_addr_W, alu_op;
    logic        sel_regb_in, sel_b, ld_flags, done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mr_control_unit #(.DW(16), .AW(3)) dut (
        .clk(clk), .rst(rst), .ir(ir), .z(z), .n(n),
        .ld_ir(ld_ir), .ld_pc(ld_pc), .sel_pc(sel_pc), .sel_addr(sel_addr),
        .mem_we(mem_we), .ld_ra(ld_ra), .regb_ld(regb_ld),
        .regb_addr_R(regb_addr_R), .regb_addr_W(regb_addr_W),
        .sel_regb_in(sel_regb_in), .sel_b(sel_b), .alu_op(alu_op),
        .ld_flags(ld_flags), .done(done)
    );

    typedef struct {
        logic        rst;
        logic [15:0] ir;
        logic        z;
        logic        n;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Field order: ld_ir ld_pc sel_pc sel_addr mem_we ld_ra regb_ld aR aW sel_in sel_b op ld_flags done
    function automatic logic [19:0] pk(input logic a, b, c, d, e, f, g,
                                        input logic [2:0] ar, aw,
                                        input logic h, i, input logic [2:0] op,
                                        input logic j, k);
        return {a, b, c, d, e, f, g, ar, aw, h, i, op, j, k};
    endfunction

    function automatic logic [19:0] act();
        return {ld_ir, ld_pc, sel_pc, sel_addr, mem_we, ld_ra, regb_ld,
                regb_addr_R, regb_addr_W, sel_regb_in, sel_b, alu_op, ld_flags, done};
    endfunction

    task automatic add(input logic r, input logic [15:0] i, input logic zz, nn,
                       input logic [19:0] e);
        vec_t v;
        v.rst = r; v.ir = i; v.z = zz; v.n = nn; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    logic [19:0] ZERO, F;

    initial begin
        ZERO = '0;
        F    = pk(1,1,0,0,0,0,0, 3'd0,3'd0, 0,0,3'd0, 0,0);
        add(1, 16'h0000, 0,0, ZERO);                                    // 0 reset
        add(1, 16'h0000, 0,0, ZERO);
        add(0, 16'h1A05, 0,0, F);                                       // LOAD
        add(0, 16'h1A05, 0,0, pk(0,0,0,0,0,1,0, 3'd2,3'd0, 0,0,3'd0, 0,0));
        add(0, 16'h1A05, 0,0, pk(0,0,0,1,0,0,1, 3'd0,3'd3, 0,0,3'd0, 1,1));
        add(0, 16'h5105, 0,0, F);                                       // 5 STORE
        add(0, 16'h5105, 0,0, pk(0,0,0,0,0,1,0, 3'd1,3'd0, 0,0,3'd0, 0,0));
        add(0, 16'h5105, 0,0, pk(0,0,0,1,1,0,0, 3'd2,3'd0, 0,0,3'd0, 0,1));
        add(0, 16'hCA44, 0,0, F);                                       // 8 ADD
        add(0, 16'hCA44, 0,0, pk(0,0,0,0,0,1,0, 3'd2,3'd0, 0,0,3'd0, 0,0));
        add(0, 16'hCA44, 0,0, pk(0,0,0,0,0,0,1, 3'd2,3'd1, 1,0,3'd4, 1,1));
        add(0, 16'hC218, 0,0, F);                                       // 11 ADDI Rd=0
        add(0, 16'hC218, 0,0, pk(0,0,0,0,0,1,0, 3'd2,3'd0, 0,0,3'd0, 0,0));
        add(0, 16'hC218, 0,0, pk(0,0,0,0,0,0,0, 3'd0,3'd0, 1,1,3'd0, 1,1));
        add(0, 16'h8820, 1,0, F);                                       // 14 BEQ taken
        add(0, 16'h8820, 1,0, pk(0,1,1,0,0,1,0, 3'd0,3'd0, 0,0,3'd0, 0,1));
        add(0, 16'h8820, 0,0, F);                                       // 16 BEQ not taken
        add(0, 16'h8820, 0,0, pk(0,0,0,0,0,1,0, 3'd0,3'd0, 0,0,3'd0, 0,1));
        add(0, 16'hA000, 1,1, F);                                       // 18 cond 100
        add(0, 16'hA000, 1,1, pk(0,0,0,0,0,1,0, 3'd0,3'd0, 0,0,3'd0, 0,1));
        add(0, 16'h9900, 0,1, F);                                       // 20 BLE n=1
        add(0, 16'h9900, 0,1, pk(0,1,1,0,0,1,0, 3'd1,3'd0, 0,0,3'd0, 0,1));
        add(0, 16'hB800, 0,0, F);                                       // 22 BG
        add(0, 16'hB800, 0,0, pk(0,1,1,0,0,1,0, 3'd0,3'd0, 0,0,3'd0, 0,1));
        add(0, 16'hD902, 0,0, F);                                       // 24 reserved op
        add(0, 16'hD902, 0,0, pk(0,0,0,0,0,1,0, 3'd1,3'd0, 0,0,3'd0, 0,0));
        add(0, 16'hD902, 0,0, pk(0,0,0,0,0,0,0, 3'd0,3'd3, 1,1,3'd2, 0,1));
        add(0, 16'h5105, 0,0, F);                                       // 27 STORE aborted
        add(0, 16'h5105, 0,0, pk(0,0,0,0,0,1,0, 3'd1,3'd0, 0,0,3'd0, 0,0));
        add(1, 16'h5105, 0,0, ZERO);
        add(0, 16'h0105, 0,0, F);                                       // 30 LOAD Rd=0
        add(0, 16'h0105, 0,0, pk(0,0,0,0,0,1,0, 3'd1,3'd0, 0,0,3'd0, 0,0));
        add(0, 16'h0105, 0,0, pk(0,0,0,1,0,0,0, 3'd0,3'd0, 0,0,3'd0, 1,1));
        add(0, 16'h1A05, 0,0, F);

        foreach (vecs[k]) begin
            rst = vecs[k].rst; ir = vecs[k].ir; z = vecs[k].z; n = vecs[k].n;
            @(negedge clk);
            chk($sformatf("vec%0d", k), 32'(act()), 32'(vecs[k].exp));
            @(posedge clk); #1;
        end

        // Reset during LOAD execute: no register/flag write, no done, FETCH after release.
        rst = 0; ir = 16'h1A05;
        @(negedge clk);
        chk("abort_decode_ra", 32'(regb_addr_R), 32'd2);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("abort_load_strobes", 32'({regb_ld, ld_flags, done, sel_addr}), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("abort_refetch", 32'({ld_ir, ld_pc, sel_addr, done}), 32'b1100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
